aco_ant_agent: RTL and testbench
================================

Name: aco_ant_agent

Overview:
- Ant-colony routing agent for one mesh router. It holds a per-destination pheromone table and picks the best productive output direction for each head-flit route request.
- It drives the one-hot request and valid inputs of the downstream ACO route calculator.
- Backward ants returning to this router reinforce the direction they travelled and evaporate the alternatives.

Parameters:
- MESH_X, 4, mesh width in nodes.
- MESH_Y, 4, mesh height in nodes.
- NODE_X, 0, this router's x coordinate.
- NODE_Y, 0, this router's y coordinate.
- PH_W, 8, pheromone entry width in bits.
- PH_INIT, 128, pheromone value after table init.
- PH_MIN, 1, evaporation floor.
- DEPOSIT, 16, saturating increment applied on reinforcement.
- EVAP_SHIFT, 3, evaporation amount is p >> EVAP_SHIFT.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- i_req_val  input  1  route request valid (head flit present).
- i_dest_x  input  $clog2(MESH_X)  destination x coordinate.
- i_dest_y  input  $clog2(MESH_Y)  destination y coordinate.
- i_ant_val  input  1  backward ant update valid.
- i_ant_dest  input  $clog2(MESH_X*MESH_Y)  destination id the ant refers to.
- i_ant_port  input  2  direction to reinforce: 0=N, 1=E, 2=S, 3=W.
- o_ready  output  1  table initialised; requests and ants are accepted.
- o_output_req  output  `M  one-hot [local, north, east, south, west]; drives the route calculator's i_output_req.
- o_val  output  1  o_output_req valid; drives the route calculator's i_val.

Behaviour:
- Clocking and reset: single clock, synchronous active-high reset. `M=5 comes from config.sv.
- Table: MESH_X*MESH_Y rows x 4 directions x PH_W bits, held in flops. Row index = dest_y*MESH_X + dest_x.
- FSM states:
  - INIT: row counter r walks 0..N-1; one row (all 4 entries) is written to PH_INIT per cycle. o_ready=0. i_req_val and i_ant_val are ignored and never queued. After row N-1 is written, the FSM moves to RUN.
  - RUN: o_ready=1. The FSM stays in RUN until reset.
- Reset:
  - Forces INIT with r=0, o_val=0, o_output_req='0, o_ready=0, from the cycle after reset is sampled.
  - Reset mid-operation discards any in-flight request and restarts the full init sequence.
  - o_ready first rises exactly N cycles after reset deasserts.
- Request path (RUN only), registered, 1-cycle latency:
  - i_req_val sampled in cycle t gives o_val=1 and o_output_req in cycle t+1.
  - With no request in t, o_val=0 and o_output_req='0 in t+1.
  - dest == (NODE_X, NODE_Y): o_output_req = 10000.
  - Otherwise the productive set is: N if dest_y<NODE_Y; S if dest_y>NODE_Y; E if dest_x>NODE_X; W if dest_x<NODE_X.
  - Choose the productive direction with the largest pheromone. Ties resolve by priority N > E > S > W.
  - Output is exactly one hot bit.
  - Non-productive directions are never selected, whatever their pheromone value.
- Ant update (RUN only), single-cycle read-modify-write on row i_ant_dest:
  - Entry at i_ant_port: p = min(p + DEPOSIT, 2^PH_W - 1).
  - Each of the other 3 entries: p = max(p - (p >> EVAP_SHIFT), PH_MIN).
  - Arithmetic is done at PH_W+1 bits, then saturated.
  - An ant with i_ant_dest equal to this node's own id, or with i_ant_dest >= N, is ignored.
- Simultaneous request and ant in the same cycle, same row: the lookup uses the pre-update values. The update is visible to requests from the next cycle on. Different rows proceed independently.
- Back-to-back: one request and one ant can be accepted every cycle with no stalls.

Test Plan:
- Init: reset high 2 cycles, then low -> o_ready=0 for 16 cycles and 1 on the 17th; requests during init give o_val=0.
- NODE=(1,1), all entries 128, request dest (3,0) -> next cycle o_val=1, o_output_req=01000 (N wins the N/E tie).
- Same node, ant dest id 3, port E -> row 3 becomes E=144, N=S=W=112; request dest (3,0) -> 00100.
- Saturation: 10 consecutive ants row 3 port E -> E=255; evaporation then floors the other entries at >=PH_MIN; requests still return 00100.
- Local, non-productive and simultaneous:
  - Request dest (1,1) -> 10000.
  - Request dest (1,3) with W pheromone maxed -> 00010 (S only productive).
  - Request and ant on the same row in the same cycle -> old winner; a repeat request the next cycle -> new winner.
- Reset mid-run after reinforcing row 3 -> re-init takes 16 cycles; row 3 is all 128 again; request dest (3,0) -> 01000.

Source files
------------

// File: rtl/aco_ant_agent.sv
// Ant-colony routing agent for one mesh router.
// Keeps a pheromone table (one row per destination, four directions per row),
// answers head-flit route requests with the strongest productive direction,
// and applies backward-ant reinforcement/evaporation to the table.
//
// Handshake: there is no backpressure. While o_ready=1 a request (i_req_val)
// and an ant update (i_ant_val) are each accepted on every clock edge where
// they are high. While o_ready=0 both are dropped. o_val is a one-cycle pulse
// qualifying o_output_req, one cycle after the accepted request.

`ifndef M
`define M 5
`endif

module aco_ant_agent #(
  parameter int MESH_X     = 4,
  parameter int MESH_Y     = 4,
  parameter int NODE_X     = 0,
  parameter int NODE_Y     = 0,
  parameter int PH_W       = 8,
  parameter int PH_INIT    = 128,
  parameter int PH_MIN     = 1,
  parameter int DEPOSIT    = 16,
  parameter int EVAP_SHIFT = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_req_val,
  input  logic [$clog2(MESH_X)-1:0]         i_dest_x,
  input  logic [$clog2(MESH_Y)-1:0]         i_dest_y,
  input  logic                              i_ant_val,
  input  logic [$clog2(MESH_X*MESH_Y)-1:0]  i_ant_dest,
  input  logic [1:0]                        i_ant_port,
  output logic                              o_ready,
  output logic [`M-1:0]                     o_output_req,
  output logic                              o_val
);

  localparam int N      = MESH_X * MESH_Y;
  localparam int IDW    = $clog2(N);
  localparam int RW     = (N > 1) ? $clog2(N) : 1;
  localparam int OWN_ID = NODE_Y * MESH_X + NODE_X;

  localparam logic [PH_W-1:0] PH_MAX    = '1;
  localparam logic [PH_W-1:0] PH_INIT_V = PH_W'(PH_INIT);
  localparam logic [PH_W-1:0] PH_MIN_V  = PH_W'(PH_MIN);

  // Direction indices inside a table row: 0=N, 1=E, 2=S, 3=W.
  localparam int DIR_N = 0;
  localparam int DIR_E = 1;
  localparam int DIR_S = 2;
  localparam int DIR_W = 3;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         r_q, r_d;
  logic                  val_q, val_d;
  logic [`M-1:0]         req_q, req_d;
  logic [PH_W-1:0]       ph_q [N][4];
  logic [PH_W-1:0]       ph_d [N][4];

  logic                  run;
  logic [IDW-1:0]        lk_idx;
  logic [PH_W-1:0]       lk_row [4];
  logic [3:0]            prod;
  logic                  is_local;
  logic                  found;
  logic [PH_W-1:0]       best_p;
  logic [1:0]            best_d;
  logic [`M-1:0]         sel_onehot;
  logic                  ant_ok;

  // Saturating reinforcement, computed one bit wider than the entry.
  function automatic logic [PH_W-1:0] ph_deposit(input logic [PH_W-1:0] p);
    logic [PH_W:0] s;
    s = {1'b0, p} + (PH_W+1)'(DEPOSIT);
    if (s > {1'b0, PH_MAX}) ph_deposit = PH_MAX;
    else                    ph_deposit = s[PH_W-1:0];
  endfunction

  // Evaporation by p >> EVAP_SHIFT, floored at PH_MIN.
  function automatic logic [PH_W-1:0] ph_evap(input logic [PH_W-1:0] p);
    logic [PH_W:0] w;
    logic [PH_W:0] e;
    w = {1'b0, p};
    e = w - (w >> EVAP_SHIFT);
    if (e < {1'b0, PH_MIN_V}) ph_evap = PH_MIN_V;
    else                      ph_evap = e[PH_W-1:0];
  endfunction

  // FSM state register plus registered request outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      r_q     <= '0;
      val_q   <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      val_q   <= val_d;
      req_q   <= req_d;
    end
  end

  // Pheromone table storage; the INIT walk rewrites every row after reset.
  always_ff @(posedge clk) begin
    ph_q <= ph_d;
  end

  // Next state: walk one row per cycle in INIT, then park in RUN.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    case (state_q)
      S_INIT: begin
        if (r_q == RW'(N - 1)) begin
          state_d = S_RUN;
          r_d     = '0;
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // FSM outputs: accept traffic only once the table is fully initialised.
  always_comb begin
    run     = (state_q == S_RUN);
    o_ready = run;
  end

  // Lookup: productive set and strongest productive entry of the request row.
  always_comb begin
    lk_idx   = IDW'(int'(i_dest_y) * MESH_X + int'(i_dest_x));
    lk_row   = ph_q[lk_idx];
    is_local = (int'(i_dest_x) == NODE_X) && (int'(i_dest_y) == NODE_Y);
    prod        = '0;
    prod[DIR_N] = int'(i_dest_y) < NODE_Y;
    prod[DIR_E] = int'(i_dest_x) > NODE_X;
    prod[DIR_S] = int'(i_dest_y) > NODE_Y;
    prod[DIR_W] = int'(i_dest_x) < NODE_X;
    found  = 1'b0;
    best_p = '0;
    best_d = 2'd0;
    // Scanning in N,E,S,W order with a strict compare keeps the earlier
    // direction on ties.
    for (int d = 0; d < 4; d++) begin
      if (prod[d] && (!found || (lk_row[d] > best_p))) begin
        found  = 1'b1;
        best_p = lk_row[d];
        best_d = 2'(d);
      end
    end
    if (is_local) sel_onehot = `M'(5'b10000);
    else          sel_onehot = `M'(5'b01000 >> best_d);
  end

  // Request register input: a pulse one cycle after each accepted request.
  always_comb begin
    val_d = run && i_req_val;
    req_d = (run && i_req_val) ? sel_onehot : '0;
  end

  // Table next value: init row write, or ant read-modify-write of one row.
  always_comb begin
    ph_d   = ph_q;
    ant_ok = run && i_ant_val &&
             (int'(i_ant_dest) != OWN_ID) && (int'(i_ant_dest) < N);
    if (state_q == S_INIT) begin
      for (int k = 0; k < 4; k++) begin
        ph_d[r_q][k] = PH_INIT_V;
      end
    end else if (ant_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (k == int'(i_ant_port)) ph_d[i_ant_dest][k] = ph_deposit(ph_q[i_ant_dest][k]);
        else                       ph_d[i_ant_dest][k] = ph_evap(ph_q[i_ant_dest][k]);
      end
    end
  end

  assign o_val        = val_q;
  assign o_output_req = req_q;

endmodule

// File: tb/tb_aco_ant_agent.sv
// Bench for aco_ant_agent at node (1,1) of a 4x4 mesh: directed steps for
// init, tie-break, reinforcement, saturation, local / non-productive routing,
// same-cycle request+ant and mid-run reset, followed by random traffic, all
// checked against a table model built from the routing and pheromone rules.

module tb_aco_ant_agent;

  localparam int MX = 4;
  localparam int MY = 4;
  localparam int NX = 1;
  localparam int NY = 1;
  localparam int NROWS = MX * MY;
  localparam int OWN = NY * MX + NX;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_req_val = 1'b0;
  logic [1:0] i_dest_x = '0;
  logic [1:0] i_dest_y = '0;
  logic       i_ant_val = 1'b0;
  logic [3:0] i_ant_dest = '0;
  logic [1:0] i_ant_port = '0;
  logic       o_ready;
  logic [4:0] o_output_req;
  logic       o_val;

  int tests = 0;
  int fails = 0;
  int init_cnt = 0;
  int model_ph [NROWS][4];

  aco_ant_agent #(
    .MESH_X(MX), .MESH_Y(MY), .NODE_X(NX), .NODE_Y(NY),
    .PH_W(8), .PH_INIT(128), .PH_MIN(1), .DEPOSIT(16), .EVAP_SHIFT(3)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_val(i_req_val), .i_dest_x(i_dest_x), .i_dest_y(i_dest_y),
    .i_ant_val(i_ant_val), .i_ant_dest(i_ant_dest), .i_ant_port(i_ant_port),
    .o_ready(o_ready), .o_output_req(o_output_req), .o_val(o_val)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference routing decision: largest productive pheromone, first in
  // N,E,S,W order among equals; local destination goes to the local port.
  function automatic logic [4:0] ref_route(input int dx, input int dy);
    bit   p [4];
    int   row;
    int   maxv;
    logic [4:0] hot [4];
    hot = '{5'b01000, 5'b00100, 5'b00010, 5'b00001};
    if (dx == NX && dy == NY) return 5'b10000;
    p[0] = dy < NY;
    p[1] = dx > NX;
    p[2] = dy > NY;
    p[3] = dx < NX;
    row  = dy * MX + dx;
    maxv = -1;
    for (int d = 0; d < 4; d++)
      if (p[d] && model_ph[row][d] > maxv) maxv = model_ph[row][d];
    for (int d = 0; d < 4; d++)
      if (p[d] && model_ph[row][d] == maxv) return hot[d];
    return 5'b00000;
  endfunction

  function automatic void model_ant(input int a, input int port);
    int v;
    if (a == OWN || a >= NROWS) return;
    for (int k = 0; k < 4; k++) begin
      v = model_ph[a][k];
      if (k == port) model_ph[a][k] = (v + 16 > 255) ? 255 : v + 16;
      else           model_ph[a][k] = (v - v / 8 < 1) ? 1 : v - v / 8;
    end
  endfunction

  // One clock of stimulus with full output check after the edge.
  task automatic step(input logic rv, input int dx, input int dy,
                      input logic av, input int ad, input int ap);
    logic       run_now;
    logic       exp_val;
    logic [4:0] exp_req;
    @(negedge clk);
    i_req_val  = rv;
    i_dest_x   = 2'(dx);
    i_dest_y   = 2'(dy);
    i_ant_val  = av;
    i_ant_dest = 4'(ad);
    i_ant_port = 2'(ap);
    run_now = (init_cnt >= NROWS);
    exp_val = run_now && rv;
    exp_req = exp_val ? ref_route(dx, dy) : 5'b00000;
    if (run_now && av) model_ant(ad, ap);
    @(posedge clk);
    #1;
    if (init_cnt < NROWS) init_cnt++;
    check("o_val", {4'b0, o_val}, {4'b0, exp_val});
    check("o_output_req", o_output_req, exp_req);
    check("o_ready", {4'b0, o_ready}, {4'b0, init_cnt >= NROWS});
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  // Reset held two cycles; a request is left pending to show it is discarded.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_req_val = 1'b1;
    i_dest_x = 2'd3;
    i_dest_y = 2'd0;
    i_ant_val = 1'b1;
    i_ant_dest = 4'd3;
    i_ant_port = 2'd1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_o_val", {4'b0, o_val}, 5'b0);
    check("rst_o_output_req", o_output_req, 5'b0);
    check("rst_o_ready", {4'b0, o_ready}, 5'b0);
    reset = 1'b0;
    i_req_val = 1'b0;
    i_ant_val = 1'b0;
    init_cnt = 0;
    for (int r = 0; r < NROWS; r++)
      for (int k = 0; k < 4; k++) model_ph[r][k] = 128;
  endtask

  initial begin
    do_reset();

    // Init: traffic ignored, o_ready rises after exactly 16 edges.
    for (int i = 0; i < NROWS; i++)
      step(1'b1, $urandom_range(0, 3), $urandom_range(0, 3),
           1'b1, $urandom_range(0, 15), $urandom_range(0, 3));
    check("ready_after_init", {4'b0, o_ready}, 5'b00001);

    // N/E tie toward (3,0) resolves to N.
    step(1'b1, 3, 0, 1'b0, 0, 0);
    check("tie_N", o_output_req, 5'b01000);
    idle();

    // One ant on row 3, port E -> E wins.
    step(1'b0, 0, 0, 1'b1, 3, 1);
    step(1'b1, 3, 0, 1'b0, 0, 0);
    check("reinforce_E", o_output_req, 5'b00100);

    // Saturation of E, evaporation of the others.
    for (int i = 0; i < 10; i++) step(1'b0, 0, 0, 1'b1, 3, 1);
    step(1'b1, 3, 0, 1'b0, 0, 0);
    check("saturate_E", o_output_req, 5'b00100);

    // Local destination.
    step(1'b1, 1, 1, 1'b0, 0, 0);
    check("local", o_output_req, 5'b10000);

    // (1,3): only S productive even with W maxed on row 13.
    for (int i = 0; i < 10; i++) step(1'b0, 0, 0, 1'b1, 13, 3);
    step(1'b1, 1, 3, 1'b0, 0, 0);
    check("nonprod_W", o_output_req, 5'b00010);

    // Ant on own id is ignored.
    step(1'b0, 0, 0, 1'b1, OWN, 3);

    // Same-cycle request and ant on row 0: old winner, then new winner.
    step(1'b1, 0, 0, 1'b1, 0, 3);
    check("simul_old", o_output_req, 5'b01000);
    step(1'b1, 0, 0, 1'b0, 0, 0);
    check("simul_new", o_output_req, 5'b00001);

    // Mid-run reset restores the table.
    step(1'b1, 3, 0, 1'b1, 3, 1);
    do_reset();
    for (int i = 0; i < NROWS; i++) step(1'b1, 3, 0, 1'b0, 0, 0);
    step(1'b1, 3, 0, 1'b0, 0, 0);
    check("reinit_tie_N", o_output_req, 5'b01000);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
